// File: rtl/fp_divider_if.sv
// Handshake/operand bundle for fp_divider.
//   start  - request; taken only while the divider is idle
//   a_fpn  - dividend, IEEE-754 single
//   b_fpn  - divisor, IEEE-754 single
//   busy   - a normal-path division is in flight
//   done   - one-cycle result-valid pulse
//   out    - quotient; held until the next done
// master drives the request side, slave is the divider.
interface fp_divider_if;
  logic        start;
  logic [31:0] a_fpn;
  logic [31:0] b_fpn;
  logic        busy;
  logic        done;
  logic [31:0] out;

  modport master (
    output start, a_fpn, b_fpn,
    input  busy, done, out
  );

  modport slave (
    input  start, a_fpn, b_fpn,
    output busy, done, out
  );
endinterface

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider, out = a_fpn / b_fpn.
// Radix-2 restoring mantissa division, one quotient bit per clock, then a
// single normalisation cycle. Truncating; denormals flush to zero; overflow
// saturates to signed infinity and underflow to signed zero. Special operands
// are resolved in the accepting cycle without entering the iterative path.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fp_divider_if.slave (start/a_fpn/b_fpn in, busy/done/out out)
//
// state | meaning
// IDLE  | waiting for start; special-operand results are produced here
// DIV   | generating quotient bits, one per cycle, ITER cycles
// NORM  | normalise quotient, compute exponent, apply range clamps
module fp_divider #(
  parameter int ITER = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] mb;
  logic [25:0] rem;
  logic [24:0] q;
  logic [4:0]  cnt;

  // Operand classification on the live inputs (used only in IDLE).
  logic [7:0]  a_exp;
  logic [7:0]  b_exp;
  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        a_zero;
  logic        b_zero;
  logic        in_sign;
  logic        is_special;
  logic [31:0] spec_result;

  always_comb begin
    a_exp   = bus.a_fpn[30:23];
    b_exp   = bus.b_fpn[30:23];
    a_nan   = (a_exp == 8'hFF) && (bus.a_fpn[22:0] != 23'd0);
    b_nan   = (b_exp == 8'hFF) && (bus.b_fpn[22:0] != 23'd0);
    a_inf   = (a_exp == 8'hFF) && (bus.a_fpn[22:0] == 23'd0);
    b_inf   = (b_exp == 8'hFF) && (bus.b_fpn[22:0] == 23'd0);
    // exponent 0 counts as zero, so denormals flush here
    a_zero  = (a_exp == 8'h00);
    b_zero  = (b_exp == 8'h00);
    in_sign = bus.a_fpn[31] ^ bus.b_fpn[31];

    is_special  = 1'b1;
    spec_result = 32'h0000_0000;
    if (a_nan || b_nan) begin
      spec_result = 32'hFFFF_FFFF;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result = 32'hFFFF_FFFF;
    end else if (a_inf || b_zero) begin
      spec_result = {in_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      spec_result = {in_sign, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start && !is_special) begin
          state_next = DIV;
        end
      end
      DIV: begin
        if (cnt == 5'(ITER - 1)) begin
          state_next = NORM;
        end
      end
      NORM: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output / result-formation logic
  logic signed [9:0] e_norm;
  logic [22:0]       mant_norm;
  logic [31:0]       norm_result;

  always_comb begin
    bus.busy = (state != IDLE);

    // q[24] set means the mantissa ratio was >= 1, so one extra bit of shift
    if (q[24]) begin
      mant_norm = q[23:1];
      e_norm    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    end else begin
      mant_norm = q[22:0];
      e_norm    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
    end

    if (e_norm >= 10'sd255) begin
      norm_result = {sign, 8'hFF, 23'd0};
    end else if (e_norm <= 10'sd0) begin
      norm_result = {sign, 31'd0};
    end else begin
      norm_result = {sign, e_norm[7:0], mant_norm};
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign     <= 1'b0;
      ea       <= 8'd0;
      eb       <= 8'd0;
      mb       <= 24'd0;
      rem      <= 26'd0;
      q        <= 25'd0;
      cnt      <= 5'd0;
      bus.out  <= 32'h0000_0000;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_special) begin
              bus.out  <= spec_result;
              bus.done <= 1'b1;
            end else begin
              sign <= in_sign;
              ea   <= a_exp;
              eb   <= b_exp;
              mb   <= {1'b1, bus.b_fpn[22:0]};
              rem  <= {2'b00, 1'b1, bus.a_fpn[22:0]};
              q    <= 25'd0;
              cnt  <= 5'd0;
            end
          end
        end
        DIV: begin
          // rem stays below 2*mb, so the left shift never overflows 26 bits
          if (rem >= {2'b00, mb}) begin
            rem <= (rem - {2'b00, mb}) << 1;
            q   <= {q[23:0], 1'b1};
          end else begin
            rem <= rem << 1;
            q   <= {q[23:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          bus.out  <= norm_result;
          bus.done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
